alu_packet_decoder: RTL
=======================

Name: alu_packet_decoder

Overview:
Responder-side framer for the host-to-device UART ALU protocol. It consumes bytes from the `uart_rx` AXI-stream output inside `uart_mod` and parses the 4-byte header: opcode, reserved, then length LSB and length MSB. It reports the command to the ALU/echo engine and streams the payload as 32-bit little-endian words. It also detects malformed packets and stalled links, and resynchronises to the next opcode byte.

Parameters:
TIMEOUT_CYCLES, 20000, idle clk_i cycles allowed between bytes mid-packet before the packet is aborted (about 15 byte times at PRESCALE 17).
OP_ECHO, 8'hEC, echo opcode; any payload byte count is allowed.
OP_ADD, 8'hAD, add opcode; payload is 32-bit operands.
OP_MUL, 8'h88, multiply opcode; payload is 32-bit operands.
OP_DIV, 8'hA2, divide opcode; payload is 32-bit operands.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous assert, active-low
rx_data_i  input  8  byte from uart_rx m_axis_tdata
rx_valid_i  input  1  byte valid
rx_ready_o  output  1  byte accept
cmd_start_o  output  1  one-cycle pulse: header accepted and opcode legal
cmd_opcode_o  output  8  opcode; held until the next header completes
cmd_len_o  output  16  payload byte count (header length minus 4); held like cmd_opcode_o
word_data_o  output  32  payload word; first byte in [7:0]
word_valid_o  output  1  word valid
word_ready_i  input  1  word accept
word_last_o  output  1  final word of the packet
word_bytes_o  output  3  valid bytes in word (1..4); always 4 except possibly the last echo word
err_o  output  1  one-cycle pulse on packet abort
err_code_o  output  2  abort cause; 1=bad opcode, 2=bad length, 3=timeout; held until the next error

Behaviour:
- Reset (rst_ni=0, async): state=IDLE; all outputs 0 except rx_ready_o=1; assembly register, byte counters and timeout counter cleared. Reset mid-packet discards everything.
- Byte handshake: a byte is accepted on a clk_i edge when rx_valid_i && rx_ready_o.
- Word handshake: a word transfers when word_valid_o && word_ready_i. Data, last and bytes are stable while valid && !ready.
- States:
  - IDLE: accepted byte -> latch opcode -> RSVD.
  - RSVD: accepted byte ignored -> LEN_L.
  - LEN_L: latch LSB -> LEN_H.
  - LEN_H: form L = {MSB, LSB}.
    - Opcode not in {OP_ECHO, OP_ADD, OP_MUL, OP_DIV}: err, code 1.
    - Else if L<4: err, code 2.
    - Else if opcode != OP_ECHO and ((L-4) mod 4 != 0 or L-4 == 0): err, code 2.
    - Else: cmd_start_o=1 on the following cycle. cmd_opcode_o/cmd_len_o update on that same edge. Next state is PAYLOAD, or IDLE when L==4.
    - Error with L>=4: next state DRAIN, remaining L-4 bytes. Error with L<4: next state IDLE.
  - PAYLOAD: bytes are packed little-endian into a 32-bit assembly register.
    - When the 4th byte, or the final packet byte, is accepted, the word moves to the output register. word_valid_o rises the next cycle; word_last_o=1 if it is the final byte; word_bytes_o = bytes packed.
    - After the final byte -> IDLE.
  - DRAIN: accept and discard bytes until the count reaches 0 -> IDLE. No words emitted.
- rx_ready_o = 0 only in PAYLOAD, when the next byte would complete a word while the output register holds an unconsumed word (word_valid_o && !word_ready_i). A same-cycle consume frees the register: ready stays 1.
- The output register is one deep. A new word loads on the same edge the old one is taken.
- err_o pulses the cycle after the error decision. err_code_o updates on the same edge.
- Timeout:
  - Counter runs in every state except IDLE.
  - It clears on each accepted byte and increments otherwise. It is frozen while rx_ready_o=0 due to backpressure.
  - On reaching TIMEOUT_CYCLES: err pulse, code 3, partial assembly discarded, -> IDLE. A word already in the output register is still delivered; word_last_o is not forced.
- Same-cycle byte and timeout expiry: the byte wins, the counter clears.
- cmd_len_o is 16 bits; L=0xFFFF gives a payload of 65531 bytes and must count correctly with no wrap.

Test Plan:
1. Send EC 00 07 00 41 42 43 -> cmd_start with opcode 0xEC, len 3; one word 0x00434241, bytes=3, last=1; state IDLE afterwards.
2. Send AD 00 0C 00 01 00 00 00 02 00 00 00 -> cmd_start len 8; words 0x00000001 (last=0), then 0x00000002 (last=1); no err.
3. Send 55 00 06 00 AA BB, then EC 00 05 00 99 -> err code 1; AA and BB drained; then cmd_start opcode 0xEC, word 0x00000099 with bytes=1, last=1.
4. Send A2 00 06 00 … -> err code 2 after the MSB byte; 2 bytes drained. Send EC 00 02 00 -> err code 2, immediate return to IDLE.
5. Send 88 00 0C 00 01 02, then hold rx_valid_i low for 20000 cycles -> err code 3 exactly at TIMEOUT_CYCLES; next opcode byte parsed as a new header.
6. Hold word_ready_i=0 during test 2 -> rx_ready_o drops when the 8th payload byte arrives. Release it -> both words delivered in order, none lost. Assert rst_ni=0 mid-payload -> all outputs 0, rx_ready_o=1 immediately.

Source files
------------

// File: rtl/alu_packet_decoder.sv
// Responder-side framer for the host-to-device UART ALU protocol.
// Parses the 4-byte header (opcode, reserved, length LSB, length MSB),
// announces legal commands, and streams the payload as 32-bit
// little-endian words. Malformed packets are drained or dropped, and a
// stalled link aborts the packet after TIMEOUT_CYCLES idle cycles.
module alu_packet_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [7:0]  OP_ECHO        = 8'hEC,
  parameter logic [7:0]  OP_ADD         = 8'hAD,
  parameter logic [7:0]  OP_MUL         = 8'h88,
  parameter logic [7:0]  OP_DIV         = 8'hA2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        cmd_start_o,
  output logic [7:0]  cmd_opcode_o,
  output logic [15:0] cmd_len_o,
  output logic [31:0] word_data_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_last_o,
  output logic [2:0]  word_bytes_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSVD,
    S_LEN_L,
    S_LEN_H,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [7:0]    opcode_q;
  logic [7:0]    len_lsb;
  logic [15:0]   remaining;   // payload or drain bytes still expected
  logic [31:0]   asm_data;    // partially assembled payload word
  logic [1:0]    byte_cnt;    // bytes already packed into asm_data
  logic [TW-1:0] tmo_cnt;

  logic        accept;
  logic        word_take;
  logic        completes;
  logic [15:0] len_full;
  logic [15:0] len_body;
  logic        is_echo;
  logic        op_legal;
  logic        len_ok;
  logic [31:0] word_next;

  assign accept    = rx_valid_i && rx_ready_o;
  assign word_take = word_valid_o && word_ready_i;

  // The byte being offered would finish a word (4th byte or last packet byte).
  assign completes = (state == S_PAYLOAD) && ((byte_cnt == 2'd3) || (remaining == 16'd1));

  // Stall only when a finishing byte has nowhere to go; a same-cycle consume frees the slot.
  assign rx_ready_o = !(completes && word_valid_o && !word_ready_i);

  assign len_full = {rx_data_i, len_lsb};
  assign len_body = len_full - 16'd4;
  assign is_echo  = (opcode_q == OP_ECHO);
  assign op_legal = is_echo || (opcode_q == OP_ADD) || (opcode_q == OP_MUL) ||
                    (opcode_q == OP_DIV);
  assign len_ok   = (len_full >= 16'd4) &&
                    (is_echo || ((len_body[1:0] == 2'b00) && (len_body != 16'd0)));

  // Merge the incoming byte into the assembly word at its little-endian lane.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    word_next = asm_data;
    word_next[{byte_cnt, 3'b000} +: 8] = rx_data_i;
  end

  // Header parser, payload packer, drain, timeout and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      opcode_q     <= '0;
      len_lsb      <= '0;
      remaining    <= '0;
      asm_data     <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      cmd_start_o  <= 1'b0;
      cmd_opcode_o <= '0;
      cmd_len_o    <= '0;
      word_data_o  <= '0;
      word_valid_o <= 1'b0;
      word_last_o  <= 1'b0;
      word_bytes_o <= '0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
      cmd_start_o <= 1'b0;
      err_o       <= 1'b0;
      if (word_take) word_valid_o <= 1'b0;

      // Inter-byte watchdog: frozen under backpressure, cleared by any accepted byte.
      if ((state != S_IDLE) && !accept) begin
        if (rx_ready_o) begin
          if (tmo_cnt == TMO_LAST) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            asm_data   <= '0;
            tmo_cnt    <= '0;
            err_o      <= 1'b1;
            err_code_o <= 2'd3;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (accept) begin
        unique case (state)
          S_IDLE: begin
            opcode_q <= rx_data_i;
            state    <= S_RSVD;
          end
          S_RSVD:  state <= S_LEN_L;
          S_LEN_L: begin
            len_lsb <= rx_data_i;
            state   <= S_LEN_H;
          end
          S_LEN_H: begin
            remaining <= len_body;
            byte_cnt  <= '0;
            asm_data  <= '0;
            if (op_legal && len_ok) begin
              cmd_start_o  <= 1'b1;
              cmd_opcode_o <= opcode_q;
              cmd_len_o    <= len_body;
              state        <= (len_body == 16'd0) ? S_IDLE : S_PAYLOAD;
            end else begin
              err_o      <= 1'b1;
              err_code_o <= op_legal ? 2'd2 : 2'd1;
              // Short lengths carry no body to skip; otherwise swallow the body.
              state      <= ((len_full < 16'd4) || (len_body == 16'd0)) ? S_IDLE : S_DRAIN;
            end
          end
          S_PAYLOAD: begin
            remaining <= remaining - 16'd1;
            if (completes) begin
              word_data_o  <= word_next;
              word_valid_o <= 1'b1;
              word_last_o  <= (remaining == 16'd1);
              word_bytes_o <= {1'b0, byte_cnt} + 3'd1;
              byte_cnt     <= '0;
              asm_data     <= '0;
            end else begin
              asm_data <= word_next;
              byte_cnt <= byte_cnt + 2'd1;
            end
            if (remaining == 16'd1) state <= S_IDLE;
          end
          S_DRAIN: begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
